// File: rtl/sl2_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sl2_shifter_pkg
// Purpose  : Shared widths and types for the shift-left-by-2 datapath unit.
// Revision : 1.0 - initial release
// ============================================================================
package sl2_shifter_pkg;

  // Datapath word width and the fixed left-shift amount (x4).
  localparam int DATA_W    = 32;
  localparam int SL2_SHIFT = 2;

  typedef logic [DATA_W-1:0] word_t;

endpackage : sl2_shifter_pkg
`default_nettype wire

// File: rtl/sl2_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : sl2_shifter_if
// Purpose  : Valid/ready bus for the shift-left unit: operand side and
//            registered result side, with master (upstream/downstream
//            environment) and slave (the unit itself) views.
// Revision : 1.0 - initial release
// ============================================================================
interface sl2_shifter_if
  import sl2_shifter_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int SHIFT = SL2_SHIFT
);

  // Operand side
  logic [N-1:0]     num;
  logic             in_valid;
  logic             in_ready;

  // Result side
  logic [N-1:0]     num4;
  logic [SHIFT-1:0] dropped;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  // Environment view: produces operands, consumes results.
  modport master (
    output num,
    output in_valid,
    input  in_ready,
    input  num4,
    input  dropped,
    input  ovf,
    input  out_valid,
    output out_ready
  );

  // Unit view: consumes operands, produces results.
  modport slave (
    input  num,
    input  in_valid,
    output in_ready,
    output num4,
    output dropped,
    output ovf,
    output out_valid,
    input  out_ready
  );

endinterface : sl2_shifter_if
`default_nettype wire

// File: rtl/sl2_shifter_comb.sv
`default_nettype none
// ============================================================================
// Module   : sl2_comb
// Purpose  : Pure combinational left shift by SHIFT. The top SHIFT bits fall
//            off (modulo-2^N wrap) and are reported, together with an
//            unsigned-overflow flag raised when any of them is set.
// Revision : 1.0 - initial release
// ============================================================================
module sl2_comb
  import sl2_shifter_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int SHIFT = SL2_SHIFT
) (
  input  wire logic [N-1:0]     num,
  output logic      [N-1:0]     num4,
  output logic      [SHIFT-1:0] dropped,
  output logic                  ovf
);

  localparam logic [SHIFT-1:0] c_zero_fill = '0;

  logic [N-1:0]     w_shifted;
  logic [SHIFT-1:0] w_dropped;

  // Shift in zeros at the bottom; the bits that leave the top are kept aside.
  always_comb begin
    w_shifted = {num[N-SHIFT-1:0], c_zero_fill};
    w_dropped = num[N-1:N-SHIFT];
  end

  // Overflow of the unsigned multiply happens exactly when a lost bit was set.
  always_comb begin
    num4    = w_shifted;
    dropped = w_dropped;
    ovf     = |w_dropped;
  end

endmodule : sl2_comb
`default_nettype wire

// File: rtl/sl2_shifter.sv
`default_nettype none
// ============================================================================
// Module   : sl2_shifter
// Purpose  : Shift-left-by-2 (x4, modulo 2^N) with a single registered
//            valid/ready stage. Full throughput: a new operand may be taken on
//            the same edge the held result leaves. Also registers the bits
//            shifted out and an overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module sl2_shifter
  import sl2_shifter_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int SHIFT = SL2_SHIFT
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  sl2_shifter_if.slave   bus
);

  // Reject parameter sets where the shift would consume the whole word or
  // leave nothing to slice.
  generate
    if ((SHIFT >= N) || (SHIFT < 1) || (N < 3)) begin : g_param_check
      $error("sl2_shifter: illegal parameters N=%0d SHIFT=%0d", N, SHIFT);
    end
  endgenerate

  logic [N-1:0]     w_num4;
  logic [SHIFT-1:0] w_dropped;
  logic             w_ovf;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;

  logic [N-1:0]     r_num4;
  logic [SHIFT-1:0] r_dropped;
  logic             r_ovf;
  logic             r_out_valid;

  sl2_comb #(
    .N     (N),
    .SHIFT (SHIFT)
  ) u_comb (
    .num     (bus.num),
    .num4    (w_num4),
    .dropped (w_dropped),
    .ovf     (w_ovf)
  );

  // Single-entry stage: room exists when empty or when the held result is
  // being taken this cycle.
  always_comb begin
    w_in_ready = !r_out_valid || bus.out_ready;
    w_accept   = bus.in_valid && w_in_ready;
    w_xfer     = r_out_valid && bus.out_ready;
  end

  // Result registers load only on accept, so a floating operand while idle
  // never reaches them and a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num4    <= '0;
      r_dropped <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_num4    <= w_num4;
      r_dropped <= w_dropped;
      r_ovf     <= w_ovf;
    end
  end

  // Valid sets on accept (also when replacing a departing result) and clears
  // when the result leaves with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.num4      = r_num4;
  assign bus.dropped   = r_dropped;
  assign bus.ovf       = r_ovf;
  assign bus.out_valid = r_out_valid;

endmodule : sl2_shifter
`default_nettype wire

// File: tb/tb_sl2_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sl2_shifter
// Purpose  : Scoreboard bench for sl2_shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sl2_shifter;
  import sl2_shifter_pkg::*;

  typedef struct packed {
    logic [31:0] num4;
    logic [1:0]  dropped;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  exp_t last_exp;

  sl2_shifter_if #(.N(32), .SHIFT(2)) bus ();

  sl2_shifter #(.N(32), .SHIFT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: true x4 product in a wider word, then split into kept/lost.
  function automatic exp_t model(input word_t v);
    logic [33:0] p;
    exp_t e;
    p         = {2'b00, v} * 34'd4;
    e.num4    = p[31:0];
    e.dropped = p[33:32];
    e.ovf     = (p[33:32] != 2'b00);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven; sample handshakes mid-cycle, compare
  // on transfer, predict on accept, then advance past the edge.
  task automatic cycle();
    exp_t e;
    logic acc;
    logic xfer;
    #1;
    acc  = bus.in_valid && bus.in_ready && rst_n;
    xfer = bus.out_valid && bus.out_ready;
    if (xfer) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("num4", {32'd0, bus.num4}, {32'd0, e.num4});
        check("dropped", {62'd0, bus.dropped}, {62'd0, e.dropped});
        check("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
      end
    end
    if (acc) begin
      e = model(bus.num);
      sb.push_back(e);
      last_exp = e;
    end
    @(posedge clk);
    #1;
    if (acc) check("latency_valid", {63'd0, bus.out_valid}, 64'd1);
  endtask

  logic [31:0] vec [0:8];

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    last_exp      = '0;
    vec[0] = 32'h00000000; vec[1] = 32'h00000001; vec[2] = 32'h00001111;
    vec[3] = 32'h0000BEEF; vec[4] = 32'h11111111; vec[5] = 32'h13579BDF;
    vec[6] = 32'hF0000000; vec[7] = 32'hFFFFFFFF; vec[8] = 32'h40000000;

    // Reset held with a live operand present.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.num       = 32'hFFFFFFFF;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_num4", {32'd0, bus.num4}, 64'd0);
    check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
    check("rst_dropped", {62'd0, bus.dropped}, 64'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    cycle();

    // Basic and overflow vectors back-to-back.
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.num      = vec[i];
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();

    // Spot-check the overflow corner directly against constants.
    bus.in_valid = 1'b1;
    bus.num      = 32'h40000000;
    cycle();
    check("ovf_vec_num4", {32'd0, bus.num4}, 64'h0);
    check("ovf_vec_dropped", {62'd0, bus.dropped}, 64'h1);
    check("ovf_vec_ovf", {63'd0, bus.ovf}, 64'h1);

    // Backpressure: accept BEEF, then stall 3 cycles with a new operand offered.
    bus.num = 32'h0000BEEF;
    cycle();
    bus.out_ready = 1'b0;
    bus.num       = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("stall_num4", {32'd0, bus.num4}, 64'h0002FBBC);
      #1;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.num       = 32'h00000001;
    cycle();
    check("bp_next_num4", {32'd0, bus.num4}, 64'h00000004);

    // Streaming: 8 random operands, no bubbles allowed.
    for (int i = 0; i < 8; i++) begin
      bus.num = $urandom;
      cycle();
      check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    bus.in_valid = 1'b0;
    cycle();
    check("drain_valid", {63'd0, bus.out_valid}, 64'd0);

    // Idle with a toggling operand: nothing loads.
    for (int i = 0; i < 6; i++) begin
      bus.num = $urandom;
      cycle();
      check("idle_valid", {63'd0, bus.out_valid}, 64'd0);
      check("idle_num4", {32'd0, bus.num4}, {32'd0, last_exp.num4});
    end

    // Reset asserted mid-stall clears valid without a clock edge.
    bus.in_valid  = 1'b1;
    bus.num       = 32'h12345678;
    cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_num4", {32'd0, bus.num4}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    check("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sl2_shifter
`default_nettype wire

// File: doc/sl2_shifter.md
Name: sl2_shifter

Overview:
Shift-left-by-2 unit for the datapath: multiplies a word by 4, e.g. branch offset to byte offset. The 2 MSBs are dropped, which is a modulo-2^N wrap with no saturation. The result is registered once behind a valid/ready handshake so it can sit between pipeline stages. It also reports the dropped bits and an overflow flag.

Parameters:
N, 32, data width in bits (N >= 3).
SHIFT, 2, fixed shift amount; only 2 is required (a SHIFT >= N value is illegal, caught by elaboration-time assertion).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
num  input  N  operand.
in_valid  input  1  operand valid.
in_ready  output  1  unit can accept operand this cycle.
num4  output  N  registered result, num << 2, low 2 bits zero.
dropped  output  2  registered num[N-1:N-2], the bits shifted out.
ovf  output  1  registered, = |dropped (unsigned overflow of x4).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.

Behaviour:
- Reset: asserting rst_n low asynchronously clears num4 = 0, dropped = 0, ovf = 0 and out_valid = 0. Release is synchronous to clk; the first capture is possible on the first rising edge after release.
- Arithmetic: num4 = {num[N-3:0], 2'b00}; dropped = num[N-1:N-2]; ovf = dropped != 0. No sign handling; the value is treated as unsigned bits.
- Handshake: in_ready = !out_valid || out_ready (combinational, single-entry stage).
- Accept when in_valid && in_ready. On that edge, load num4/dropped/ovf and set out_valid = 1.
- Latency is 1 cycle; throughput is 1 per cycle while out_ready = 1.
- Output transfer occurs when out_valid && out_ready. If no new accept happens on the same edge, out_valid clears; the data registers hold their last value.
- Simultaneous output transfer and input accept: the new result replaces the old one and out_valid stays 1, with no bubble.
- Stall: out_valid = 1 and out_ready = 0 gives in_ready = 0. num4/dropped/ovf must be held stable until transferred.
- in_valid while in_ready = 0: the operand is ignored; the upstream side must hold it.
- Reset mid-operation: any held result is discarded and out_valid clears immediately.
- No X propagation: with in_valid = 0 the registers do not load, whatever the value on num.

Decomposition:
- Shared package holds: DATA_W = 32, SL2_SHIFT = 2, and a word_t typedef logic [DATA_W-1:0].
- One natural sub-module: sl2_comb, the pure combinational shift plus dropped/ovf logic.
- sl2_shifter wraps sl2_comb with the handshake register stage.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 and num = 0xFFFFFFFF -> out_valid = 0, num4 = 0, ovf = 0. Assert rst_n mid-stall -> out_valid drops immediately, without waiting for a clock.
- Basic vectors, out_ready = 1, one per cycle. Each result appears 1 cycle later with ovf = 0:
  - 0x00000000 -> 0x00000000
  - 0x00000001 -> 0x00000004
  - 0x00001111 -> 0x00004444
  - 0x0000BEEF -> 0x0002FBBC
  - 0x11111111 -> 0x44444444
  - 0x13579BDF -> 0x4D5E6F7C
- Overflow:
  - 0xF0000000 -> num4 = 0xC0000000, dropped = 2'b11, ovf = 1.
  - 0xFFFFFFFF -> num4 = 0xFFFFFFFC, dropped = 2'b11, ovf = 1.
  - 0x40000000 -> num4 = 0x00000000, dropped = 2'b01, ovf = 1.
- Backpressure: out_ready = 0 for 3 cycles after accepting 0x0000BEEF -> in_ready = 0 and num4 stays 0x0002FBBC. Then raise out_ready with in_valid = 1 and num = 0x00000001 -> back-to-back transfer, next num4 = 0x00000004.
- Streaming: 8 back-to-back operands with out_ready = 1 -> 8 results in order, out_valid continuously 1, no bubbles.
- Idle: in_valid = 0 while num toggles randomly -> out_valid remains 0 and the registers do not change.
